// File: rtl/scan_chain_sequencer.sv
// Byte-stream sequencer for the core's scan chain (LSB-first shift with readback)
// and for bounded processor runs via proc_en/halt.
module scan_chain_sequencer #(
  parameter int CHAIN_LEN = 136,
  parameter int RUN_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_load,
  input  logic             start_run,
  input  logic             abort,
  input  logic [RUN_W-1:0] run_limit,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             scan_enable,
  output logic             scan_in_bit,
  input  logic             scan_out_bit,
  output logic             proc_en,
  input  logic             halt,
  output logic             busy,
  output logic             done,
  output logic             timeout
);

  // Remaining-bit counter is at least 4 bits wide so the compare against 8 never truncates.
  localparam int RW = ($clog2(CHAIN_LEN + 1) < 4) ? 4 : $clog2(CHAIN_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_WAIT,
    S_SHIFT,
    S_OUT_WAIT,
    S_RUN
  } state_e;

  state_e           state_q, state_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic [3:0]       n_q, n_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       out_q, out_d;
  logic [RUN_W-1:0] limit_q, limit_d;
  logic [RUN_W-1:0] cnt_q, cnt_d;
  logic [RUN_W-1:0] cnt_inc;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;

  assign cnt_inc = cnt_q + RUN_W'(1);

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    n_d       = n_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    out_d     = out_q;
    limit_d   = limit_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (start_load) begin
          state_d   = S_LOAD_WAIT;
          rem_d     = RW'(CHAIN_LEN);
          timeout_d = 1'b0;
        end else if (start_run) begin
          state_d   = S_RUN;
          limit_d   = run_limit;
          cnt_d     = '0;
          timeout_d = 1'b0;
        end
      end
      S_LOAD_WAIT: begin
        if (in_valid) begin
          state_d = S_SHIFT;
          shreg_d = in_data;
          out_d   = 8'h00;
          bit_d   = 3'd0;
          n_d     = (rem_q >= RW'(8)) ? 4'd8 : rem_q[3:0];
        end
      end
      S_SHIFT: begin
        out_d[bit_q] = scan_out_bit;
        shreg_d      = {1'b0, shreg_q[7:1]};
        rem_d        = rem_q - RW'(1);
        bit_d        = bit_q + 3'd1;
        if (({1'b0, bit_q} + 4'd1) == n_q) state_d = S_OUT_WAIT;
      end
      S_OUT_WAIT: begin
        if (out_ready) begin
          if (rem_q == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_LOAD_WAIT;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_inc;
        // halt has priority over the cycle limit when both land together
        if (halt) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if ((limit_q != '0) && (cnt_inc == limit_q)) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d   = S_IDLE;
      done_d    = 1'b0;
      timeout_d = timeout_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      n_q       <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      out_q     <= '0;
      limit_q   <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      n_q       <= n_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      out_q     <= out_d;
      limit_q   <= limit_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign in_ready    = (state_q == S_LOAD_WAIT);
  assign out_valid   = (state_q == S_OUT_WAIT);
  assign scan_enable = (state_q == S_SHIFT);
  assign proc_en     = (state_q == S_RUN);
  assign scan_in_bit = scan_enable & shreg_q[0];
  assign out_data    = out_q;
  assign done        = done_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_scan_chain_sequencer.sv
// Bench for scan_chain_sequencer with a 12-bit chain model standing in for the core.
module tb_scan_chain_sequencer;
  localparam int CL    = 12;
  localparam int NB    = (CL + 7) / 8;
  localparam int RUN_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_load = 1'b0, start_run = 1'b0, abort = 1'b0;
  logic [RUN_W-1:0] run_limit = '0;
  logic [7:0]       in_data = 8'h00;
  logic             in_valid = 1'b0, in_ready;
  logic [7:0]       out_data;
  logic             out_valid, out_ready = 1'b0;
  logic             scan_enable, scan_in_bit, scan_out_bit;
  logic             proc_en, halt = 1'b0;
  logic             busy, done, timeout;

  logic [CL-1:0]    chain = 12'h3C6;
  int               se_tot = 0, pe_tot = 0, done_tot = 0, inv_bad = 0;
  logic             sin_log[$];
  int               nchk = 0, npass = 0;

  always #5 clk = ~clk;

  scan_chain_sequencer #(.CHAIN_LEN(CL), .RUN_W(RUN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start_load(start_load), .start_run(start_run),
    .abort(abort), .run_limit(run_limit), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .scan_enable(scan_enable), .scan_in_bit(scan_in_bit),
    .scan_out_bit(scan_out_bit), .proc_en(proc_en), .halt(halt), .busy(busy),
    .done(done), .timeout(timeout)
  );

  // Core-side chain: shifts toward bit 0 while scan_enable is high.
  assign scan_out_bit = chain[0];
  always @(posedge clk) if (scan_enable) chain <= {scan_in_bit, chain[CL-1:1]};

  always @(negedge clk) begin
    if (scan_enable) begin
      se_tot <= se_tot + 1;
      sin_log.push_back(scan_in_bit);
    end
    if (proc_en) pe_tot <= pe_tot + 1;
    if (done) done_tot <= done_tot + 1;
    if ((scan_enable && proc_en) || (in_ready && out_valid)) inv_bad <= inv_bad + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic ld, input logic rn);
    start_load = ld;
    start_run  = rn;
    step();
    start_load = 1'b0;
    start_run  = 1'b0;
  endtask

  task automatic do_load(input logic [8*NB-1:0] img, input int bp_first);
    logic [CL-1:0] pre, got;
    logic [7:0]    exp_rb, hold;
    int            se0, sq0, d0, seb, w, bp;
    pre = chain; se0 = se_tot; sq0 = sin_log.size(); d0 = done_tot;
    pulse_start(1'b1, 1'b0);
    chk("load_busy", 32'(busy), 1);
    chk("load_to_clr", 32'(timeout), 0);
    for (int b = 0; b < NB; b++) begin
      in_data  = img[8*b +: 8];
      in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 50) begin step(); w++; end
      if (!in_ready) begin chk("in_ready_wait", 0, 1); in_valid = 1'b0; return; end
      step();
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      w = 0;
      while (!out_valid && w < 50) begin step(); w++; end
      if (!out_valid) begin chk("out_valid_wait", 0, 1); return; end
      exp_rb = 8'(pre >> (8 * b));
      bp   = (b == 0) ? bp_first : int'($urandom_range(0, 3));
      hold = out_data;
      seb  = se_tot;
      for (int k = 0; k < bp; k++) step();
      if (bp > 0) begin
        chk("bp_scan_hold", 32'(se_tot - seb), 0);
        chk("bp_data_stable", 32'(out_data), 32'(hold));
        chk("bp_in_ready", 32'({out_valid, in_ready}), 32'h2);
      end
      out_ready = 1'b1;
      chk("readback", 32'(out_data), 32'(exp_rb));
      step();
      out_ready = 1'b0;
      chk("done_at_end", 32'(done), (b == NB - 1) ? 1 : 0);
    end
    step();
    chk("done_once", 32'(done_tot - d0), 1);
    chk("load_idle", 32'(busy), 0);
    chk("se_count", 32'(se_tot - se0), CL);
    for (int i = 0; i < CL; i++) got[i] = sin_log[sq0 + i];
    chk("scan_in_seq", 32'(got), 32'(img[CL-1:0]));
    chk("chain_image", 32'(chain), 32'(img[CL-1:0]));
  endtask

  task automatic do_run(input int limit, input int halt_at);
    int pe0, d0, w, k, exp_pe;
    logic exp_halt;
    exp_halt = (halt_at != 0) && (limit == 0 || halt_at <= limit);
    exp_pe   = exp_halt ? halt_at : limit;
    pe0 = pe_tot; d0 = done_tot;
    run_limit = RUN_W'(limit);
    pulse_start(1'b0, 1'b1);
    run_limit = RUN_W'($urandom);
    chk("run_busy", 32'(busy), 1);
    chk("run_to_clr", 32'(timeout), 0);
    k = 1; w = 0;
    while (busy && w < 300) begin
      halt = (k == halt_at);
      step();
      k++; w++;
    end
    halt = 1'b0;
    if (busy) begin chk("run_end_wait", 0, 1); return; end
    chk("run_done", 32'(done), 32'(exp_halt));
    chk("run_timeout", 32'(timeout), 32'(!exp_halt));
    step();
    chk("pe_count", 32'(pe_tot - pe0), 32'(exp_pe));
    chk("run_done_cnt", 32'(done_tot - d0), 32'(exp_halt));
  endtask

  initial begin
    int pe0, d0, w;
    // reset state
    #3;
    chk("reset_outs", 32'({scan_enable, proc_en, in_ready, out_valid, done, timeout,
                           busy, scan_in_bit, out_data}), 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // directed 12-bit load with 5-cycle backpressure on the first readback
    do_load(16'h0CA5, 5);

    // asynchronous reset in the middle of a shift
    pulse_start(1'b1, 1'b0);
    in_data = 8'($urandom); in_valid = 1'b1;
    w = 0;
    while (!scan_enable && w < 50) begin step(); w++; end
    in_valid = 1'b0;
    chk("midshift_reached", 32'(scan_enable), 1);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("midshift_reset", 32'({scan_enable, proc_en, in_ready, out_valid, done, timeout,
                               busy, scan_in_bit, out_data}), 0);
    step();
    rst_n = 1'b1;
    step();
    do_load(16'($urandom), 2);

    // runs
    do_run(0, 7);
    do_run(10, 0);
    do_run(0, 1);
    do_run(5, 5);

    // simultaneous starts: load wins, then abort out of LOAD_WAIT
    pe0 = pe_tot; d0 = done_tot;
    pulse_start(1'b1, 1'b1);
    chk("both_load", 32'({in_ready, proc_en}), 32'h2);
    abort = 1'b1; step(); abort = 1'b0;
    chk("abort_load_idle", 32'({busy, done}), 0);
    step();
    chk("both_no_run", 32'(pe_tot - pe0), 0);

    // abort during RUN
    run_limit = '0;
    pulse_start(1'b0, 1'b1);
    step(); step(); step();
    abort = 1'b1; step(); abort = 1'b0;
    chk("abort_run_idle", 32'({proc_en, busy, done, timeout}), 0);
    step();
    chk("abort_no_done", 32'(done_tot - d0), 0);
    chk("abort_pe_cycles", 32'(pe_tot - pe0), 4);

    // randomized mix
    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        do_load(16'($urandom), int'($urandom_range(0, 4)));
      end else if ($urandom_range(0, 2) == 0) begin
        do_run(0, int'($urandom_range(1, 20)));
      end else begin
        do_run(int'($urandom_range(1, 20)), int'($urandom_range(0, 25)));
      end
    end

    chk("invariants", 32'(inv_bad), 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
